// File: rtl/fir_pkg.sv
// Shared helpers for the distributed-arithmetic FIR family: width derivation and
// the partial-sum table builder evaluated at elaboration time.
package fir_pkg;

    localparam int MAX_TAPS     = 8;
    localparam int ENTRY_W      = 32;
    localparam int COEFFS_MAX_W = 1024;

    typedef logic [(2**MAX_TAPS)*ENTRY_W-1:0] psum_table_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int out_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + clog2(taps) + 1;
    endfunction

    // Coefficient idx as a signed integer; the packed field is two's complement.
    function automatic longint coef_at(input logic [COEFFS_MAX_W-1:0] coeffs,
                                       input int coef_w, input int idx);
        longint value;
        value = 0;
        for (int b = 0; b < coef_w; b++) begin
            value[b] = coeffs[idx*coef_w + b];
        end
        if (coeffs[idx*coef_w + coef_w - 1]) begin
            value = value - (longint'(1) << coef_w);
        end
        return value;
    endfunction

    function automatic psum_table_t build_psum_table(input int taps, input int coef_w,
                                                     input logic [COEFFS_MAX_W-1:0] coeffs);
        psum_table_t tbl;
        longint      sum;
        tbl = '0;
        for (int a = 0; a < (1 << taps); a++) begin
            sum = 0;
            for (int i = 0; i < taps; i++) begin
                if (((a >> i) & 1) != 0) begin
                    sum = sum + coef_at(coeffs, coef_w, i);
                end
            end
            tbl[a*ENTRY_W +: ENTRY_W] = sum[ENTRY_W-1:0];
        end
        return tbl;
    endfunction

    function automatic longint max_abs_psum(input int taps, input int coef_w,
                                            input logic [COEFFS_MAX_W-1:0] coeffs);
        longint sum;
        longint h;
        sum = 0;
        for (int i = 0; i < taps; i++) begin
            h = coef_at(coeffs, coef_w, i);
            sum = sum + ((h < 0) ? -h : h);
        end
        return sum;
    endfunction

endpackage

// File: rtl/da_fir_serial_lut.sv
// Combinational partial-sum ROM: psum = sum of h[i] for every set bit i of addr.
// Shared with the parallel-DA 2D variant.
module da_lut
    import fir_pkg::*;
#(
    parameter int TAPS   = 4,
    parameter int COEF_W = 8,
    parameter logic [TAPS*COEF_W-1:0] COEFFS = {8'sd3, -8'sd1, 8'sd2, 8'sd1}
) (
    input  logic [TAPS-1:0]                       addr,
    output logic signed [COEF_W+clog2(TAPS)-1:0]  psum
);

    localparam int          PSUM_W = COEF_W + clog2(TAPS);
    localparam psum_table_t TABLE  = build_psum_table(TAPS, COEF_W, COEFFS_MAX_W'(COEFFS));

    logic [PSUM_W-1:0] rom [2**TAPS];

    for (genvar a = 0; a < 2**TAPS; a++) begin : g_rom
        assign rom[a] = TABLE[a*ENTRY_W +: PSUM_W];
    end

    assign psum = rom[addr];

endmodule

// File: rtl/da_fir_serial.sv
// Bit-serial distributed-arithmetic FIR: one input bit slice per clock, LSB first,
// with valid/ready handshakes on both sides and a full-precision result.
module da_fir_serial
    import fir_pkg::*;
#(
    parameter int TAPS   = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter logic [TAPS*COEF_W-1:0] COEFFS = {8'sd3, -8'sd1, 8'sd2, 8'sd1},
    parameter bit SIGNED_IN = 1'b1,
    parameter int OUT_W  = out_width(DATA_W, COEF_W, TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  y_out
);

    localparam int PSUM_W = COEF_W + clog2(TAPS);
    localparam int CNT_W  = (clog2(DATA_W) > 0) ? clog2(DATA_W) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    if (TAPS < 2 || TAPS > MAX_TAPS) begin : g_bad_taps
        $error("da_fir_serial: TAPS must be in 2..8");
    end

    if ((max_abs_psum(TAPS, COEF_W, COEFFS_MAX_W'(COEFFS)) << DATA_W) >
        (longint'(1) << (OUT_W - 1))) begin : g_overflow
        $error("da_fir_serial: worst-case result does not fit OUT_W");
    end

    logic [1:0]              state;
    logic [DATA_W-1:0]       tap [TAPS];
    logic [CNT_W-1:0]        cnt;
    logic signed [OUT_W-1:0] acc;
    logic [TAPS-1:0]         addr;
    logic signed [PSUM_W-1:0] psum;
    logic signed [OUT_W-1:0] psum_ext;
    logic signed [OUT_W-1:0] shifted;
    logic signed [OUT_W-1:0] acc_next;
    logic                    last;

    // Each tap contributes the bit of its sample selected by the bit counter.
    always_comb begin
        addr = '0;
        for (int i = 0; i < TAPS; i++) begin
            addr[i] = tap[i][cnt];
        end
    end

    da_lut #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W),
        .COEFFS (COEFFS)
    ) u_lut (
        .addr (addr),
        .psum (psum)
    );

    // The MSB slice of a two's complement sample carries negative weight.
    assign last     = (cnt == CNT_W'(DATA_W - 1));
    assign psum_ext = OUT_W'(psum);
    assign shifted  = psum_ext <<< cnt;
    assign acc_next = (last && SIGNED_IN) ? (acc - shifted) : (acc + shifted);
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                tap[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tap[0] <= x_in;
                        for (int i = 1; i < TAPS; i++) begin
                            tap[i] <= tap[i-1];
                        end
                        acc   <= '0;
                        cnt   <= '0;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc <= acc_next;
                    if (last) begin
                        y_out     <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_da_fir_serial.sv
// Self-checking bench for da_fir_serial: signed and unsigned instances compared
// against a direct-form convolution model of y[n] = sum h[i]*x[n-i].
module tb_da_fir_serial;

    localparam int TAPS   = 4;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int OUT_W  = 19;
    localparam logic [TAPS*COEF_W-1:0] COEFFS = {8'sd3, -8'sd1, 8'sd2, 8'sd1};

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] x_in;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  y_out;

    logic              in_valid_u;
    logic              in_ready_u;
    logic [DATA_W-1:0] x_in_u;
    logic              out_valid_u;
    logic              out_ready_u;
    logic [OUT_W-1:0]  y_out_u;

    int tests_run;
    int tests_failed;
    int cycle;

    int h [TAPS] = '{1, 2, -1, 3};
    int hist_s [TAPS];
    int hist_u [TAPS];

    da_fir_serial #(
        .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .COEFFS(COEFFS), .SIGNED_IN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out)
    );

    da_fir_serial #(
        .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .COEFFS(COEFFS), .SIGNED_IN(1'b0)
    ) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid_u), .in_ready(in_ready_u), .x_in(x_in_u),
        .out_valid(out_valid_u), .out_ready(out_ready_u), .y_out(y_out_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Push one sample into the model history and return the convolution result.
    function automatic int model_step(input bit uns, input logic [DATA_W-1:0] x);
        int y;
        y = 0;
        if (uns) begin
            for (int i = TAPS-1; i > 0; i--) hist_u[i] = hist_u[i-1];
            hist_u[0] = int'(x);
            for (int i = 0; i < TAPS; i++) y += h[i] * hist_u[i];
        end else begin
            for (int i = TAPS-1; i > 0; i--) hist_s[i] = hist_s[i-1];
            hist_s[0] = int'($signed(x));
            for (int i = 0; i < TAPS; i++) y += h[i] * hist_s[i];
        end
        return y;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < TAPS; i++) begin
            hist_s[i] = 0;
            hist_u[i] = 0;
        end
    endfunction

    // Called and returning at posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_valid_u = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic send_sample(input bit uns, input logic [DATA_W-1:0] x,
                               output int y, output int lat, output int acc_cycle,
                               output bit ok);
        int guard;
        logic signed [OUT_W-1:0] got;
        ok = 1'b1;
        guard = 0;
        while (!(uns ? in_ready_u : in_ready) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) ok = 1'b0;
        if (uns) begin x_in_u = x; in_valid_u = 1'b1; end
        else     begin x_in   = x; in_valid   = 1'b1; end
        @(posedge clk); #1;
        acc_cycle = cycle;
        in_valid = 1'b0;
        in_valid_u = 1'b0;
        lat = 0;
        while (!(uns ? out_valid_u : out_valid) && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!(uns ? out_valid_u : out_valid)) ok = 1'b0;
        got = uns ? y_out_u : y_out;
        y = int'(got);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_out !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b y_out=%0d, required 1 0 0",
                     in_ready, out_valid, y_out);
        end
        tests_run++;
        if (in_ready_u !== 1'b1 || out_valid_u !== 1'b0 || y_out_u !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state_u: in_ready=%b out_valid=%b y_out=%0d, required 1 0 0",
                     in_ready_u, out_valid_u, y_out_u);
        end
        // in_valid offered while reset is held must not start a computation
        rst = 1'b1;
        x_in = 8'd55;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL valid_during_reset: in_ready=%b out_valid=%b, required 1 0",
                     in_ready, out_valid);
        end
        model_clear();
    endtask

    task automatic run_list(input string name, input bit uns, input int xs [],
                            input int expect_list []);
        int y, lat, acc_cycle, exp_model;
        bit ok;
        for (int k = 0; k < xs.size(); k++) begin
            send_sample(uns, DATA_W'(xs[k]), y, lat, acc_cycle, ok);
            exp_model = model_step(uns, DATA_W'(xs[k]));
            tests_run++;
            if (!ok || y !== expect_list[k] || y !== exp_model) begin
                tests_failed++;
                $display("[TB] FAIL %s[%0d]: y_out=%0d ok=%b, required %0d (model %0d)",
                         name, k, y, ok, expect_list[k], exp_model);
            end
            tests_run++;
            if (lat !== DATA_W) begin
                tests_failed++;
                $display("[TB] FAIL %s_latency[%0d]: %0d edges, required %0d", name, k, lat, DATA_W);
            end
        end
    endtask

    task automatic test_impulse();
        do_reset();
        run_list("impulse", 1'b0, '{1, 0, 0, 0}, '{1, 2, -1, 3});
    endtask

    task automatic test_sequence();
        do_reset();
        run_list("sequence", 1'b0, '{6, 9, 0, 2}, '{6, 21, 12, 11});
    endtask

    task automatic test_signed_extreme();
        do_reset();
        run_list("signed_extreme", 1'b0, '{128, 128, 128, 128}, '{-128, -384, -256, -640});
    endtask

    task automatic test_unsigned();
        do_reset();
        run_list("unsigned", 1'b1, '{255, 255}, '{255, 765});
    endtask

    task automatic test_back_to_back();
        int y, lat, acc_cycle, prev_cycle, exp_y;
        bit ok;
        logic [DATA_W-1:0] x;
        bit uns;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            uns = (pass == 1);
            prev_cycle = -1;
            for (int k = 0; k < 16; k++) begin
                x = DATA_W'($urandom);
                send_sample(uns, x, y, lat, acc_cycle, ok);
                exp_y = model_step(uns, x);
                tests_run++;
                if (!ok || y !== exp_y || lat !== DATA_W) begin
                    tests_failed++;
                    $display("[TB] FAIL random%s[%0d]: x=%0d y_out=%0d lat=%0d ok=%b, required %0d lat %0d",
                             uns ? "_u" : "", k, x, y, lat, ok, exp_y, DATA_W);
                end
                if (prev_cycle >= 0) begin
                    tests_run++;
                    if (acc_cycle - prev_cycle !== DATA_W + 2) begin
                        tests_failed++;
                        $display("[TB] FAIL throughput%s[%0d]: %0d cycles, required %0d",
                                 uns ? "_u" : "", k, acc_cycle - prev_cycle, DATA_W + 2);
                    end
                end
                prev_cycle = acc_cycle;
            end
        end
    endtask

    task automatic test_backpressure();
        int y, lat, acc_cycle, exp_y;
        bit ok;
        bit bad;
        do_reset();
        out_ready = 1'b0;
        send_sample(1'b0, 8'd7, y, lat, acc_cycle, ok);
        exp_y = model_step(1'b0, 8'd7);
        tests_run++;
        if (!ok || y !== exp_y) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_value: y_out=%0d ok=%b, required %0d", y, ok, exp_y);
        end
        bad = 1'b0;
        x_in = 8'd99;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'($signed(y_out)) !== exp_y) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_hold: out_valid=%b in_ready=%b y_out=%0d, required 1 0 %0d",
                     out_valid, in_ready, $signed(y_out), exp_y);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || int'($signed(y_out)) !== exp_y) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_release: in_ready=%b out_valid=%b y_out=%0d, required 1 0 %0d",
                     in_ready, out_valid, $signed(y_out), exp_y);
        end
        // The sample offered during DONE must not have entered the delay line
        send_sample(1'b0, 8'd1, y, lat, acc_cycle, ok);
        exp_y = model_step(1'b0, 8'd1);
        tests_run++;
        if (!ok || y !== exp_y) begin
            tests_failed++;
            $display("[TB] FAIL done_not_accepted: y_out=%0d ok=%b, required %0d", y, ok, exp_y);
        end
    endtask

    task automatic test_mid_reset();
        int y, lat, acc_cycle, exp_y;
        bit ok;
        bit saw_valid;
        do_reset();
        send_sample(1'b0, 8'd5, y, lat, acc_cycle, ok);
        exp_y = model_step(1'b0, 8'd5);
        tests_run++;
        if (!ok || y !== exp_y) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_prefill: y_out=%0d ok=%b, required %0d", y, ok, exp_y);
        end
        @(posedge clk); #1;
        x_in = 8'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL busy_in_ready: in_ready=%b, required 0", in_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        saw_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid !== 1'b0) saw_valid = 1'b1;
            @(posedge clk); #1;
        end
        tests_run++;
        if (saw_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL aborted_result: out_valid seen=%b in_ready=%b, required 0 1",
                     saw_valid, in_ready);
        end
        send_sample(1'b0, 8'd6, y, lat, acc_cycle, ok);
        exp_y = model_step(1'b0, 8'd6);
        tests_run++;
        if (!ok || y !== 6 || y !== exp_y) begin
            tests_failed++;
            $display("[TB] FAIL after_mid_reset: y_out=%0d ok=%b, required 6 (model %0d)", y, ok, exp_y);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        cycle = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_valid_u = 1'b0;
        x_in = '0;
        x_in_u = '0;
        out_ready = 1'b1;
        out_ready_u = 1'b1;
        model_clear();

        test_reset();
        test_impulse();
        test_sequence();
        test_signed_extreme();
        test_unsigned();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
